// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory port arbiter.
//   state_e  : access sequencer states IDLE/ISSUE/WAIT/RESP
//   PORT_CPU : requester id of the CPU MEM stage (port 0)
//   PORT_LDR : requester id of the loader/debug master (port 1)
//   LAT_W    : width of the memory latency down-counter (MEM_LAT up to 7)
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_LDR = 1'b1;

    localparam int unsigned LAT_W = 3;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick with a single priority pointer flop.
//   clk_i   in  clock
//   rst_i   in  synchronous active-low reset (pointer -> PORT_CPU)
//   req_i   in  [1:0] request vector, bit N = port N
//   take_i  in  the current pick is accepted this cycle
//   valid_o out at least one request present
//   id_o    out winning port id
module rr_arb2
    import dmem_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic       take_i,
    output logic       valid_o,
    output logic       id_o
);

    logic prio_q, prio_d;

    always_comb begin
        valid_o = |req_i;
        if (&req_i) begin
            id_o = prio_q;
        end else begin
            id_o = req_i[PORT_LDR] ? PORT_LDR : PORT_CPU;
        end
    end

    // Only a contested grant moves the pointer; it then favours the loser.
    always_comb begin
        prio_d = prio_q;
        if (take_i && (&req_i)) begin
            prio_d = ~id_o;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            prio_q <= PORT_CPU;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares a single-port data memory between the CPU MEM stage (m0) and the
// loader/debug master (m1). Each access is sequenced IDLE -> ISSUE -> WAIT -> RESP
// over the memory's fixed read latency; the CPU is stalled while its access is open.
//   clk_i, rst_i             clock, synchronous active-low reset
//   mN_req_i/we_i/addr_i/    requester N: request (held until gnt), write flag,
//   mN_wdata_i               byte address and write data (stable while req high)
//   mN_gnt_o                 1-cycle accept pulse
//   mN_rvalid_o/mN_rdata_o   1-cycle completion pulse, read data (0 otherwise / on writes)
//   mem_en_o/we_o/addr_o/    1-cycle memory strobe with qualified write enable,
//   mem_wdata_o              address and write data
//   mem_rdata_i              memory read data, MEM_LAT cycles after mem_en_o
//   stall_o                  CPU stall: m0 requesting or in flight, not yet completed
//   stall_cnt_o              saturating count of stall_o cycles
module dmem_port_arbiter
    import dmem_pkg::*;
#(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned MEM_LAT = 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          m0_req_i,
    input  logic          m0_we_i,
    input  logic [AW-1:0] m0_addr_i,
    input  logic [DW-1:0] m0_wdata_i,
    output logic          m0_gnt_o,
    output logic          m0_rvalid_o,
    output logic [DW-1:0] m0_rdata_o,
    input  logic          m1_req_i,
    input  logic          m1_we_i,
    input  logic [AW-1:0] m1_addr_i,
    input  logic [DW-1:0] m1_wdata_i,
    output logic          m1_gnt_o,
    output logic          m1_rvalid_o,
    output logic [DW-1:0] m1_rdata_o,
    output logic          mem_en_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    input  logic [DW-1:0] mem_rdata_i,
    output logic          stall_o,
    output logic [31:0]   stall_cnt_o
);

    state_e          state_q, state_d;
    logic            id_q, id_d;
    logic            we_q, we_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [LAT_W-1:0] cnt_q, cnt_d;
    logic [31:0]     stall_cnt_q, stall_cnt_d;

    logic arb_valid, arb_id, pick;
    logic issue, resp, rd_ok;

    rr_arb2 u_arb (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .req_i   ({m1_req_i, m0_req_i}),
        .take_i  (pick),
        .valid_o (arb_valid),
        .id_o    (arb_id)
    );

    // RESP also arbitrates so a waiting requester is issued right after the
    // previous completion, keeping back-to-back accesses MEM_LAT+2 apart.
    assign pick = ((state_q == IDLE) || (state_q == RESP)) && arb_valid;

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE, RESP: begin
                if (pick) begin
                    state_d = ISSUE;
                    id_d    = arb_id;
                    we_d    = (arb_id == PORT_LDR) ? m1_we_i    : m0_we_i;
                    addr_d  = (arb_id == PORT_LDR) ? m1_addr_i  : m0_addr_i;
                    wdata_d = (arb_id == PORT_LDR) ? m1_wdata_i : m0_wdata_i;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                cnt_d   = LAT_W'(MEM_LAT - 1);
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign issue = (state_q == ISSUE);
    assign resp  = (state_q == RESP);
    assign rd_ok = resp && !we_q;

    assign m0_gnt_o    = issue && (id_q == PORT_CPU);
    assign m1_gnt_o    = issue && (id_q == PORT_LDR);
    assign m0_rvalid_o = resp && (id_q == PORT_CPU);
    assign m1_rvalid_o = resp && (id_q == PORT_LDR);
    assign m0_rdata_o  = (rd_ok && (id_q == PORT_CPU)) ? mem_rdata_i : '0;
    assign m1_rdata_o  = (rd_ok && (id_q == PORT_LDR)) ? mem_rdata_i : '0;

    assign mem_en_o    = issue;
    assign mem_we_o    = issue && we_q;
    assign mem_addr_o  = issue ? addr_q  : '0;
    assign mem_wdata_o = issue ? wdata_q : '0;

    // Held low during reset so every output reads 0 while rst_i is asserted.
    assign stall_o = rst_i && !m0_rvalid_o &&
                     (m0_req_i || ((state_q != IDLE) && (id_q == PORT_CPU)));

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_o && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            id_q        <= PORT_CPU;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cnt_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            id_q        <= id_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter: instance u_a (MEM_LAT=1) and u_b (MEM_LAT=3),
// each with its own behavioural memory. Per-cycle output bits are collected into
// vectors (bit i = cycle i of a transaction window) and compared to hand-derived values.
module tb_dmem_port_arbiter;
    import dmem_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // instance A signals
    logic        m0_req_a, m0_we_a, m1_req_a, m1_we_a;
    logic [31:0] m0_addr_a, m0_wdata_a, m1_addr_a, m1_wdata_a;
    logic        m0_gnt_a, m0_rvalid_a, m1_gnt_a, m1_rvalid_a;
    logic [31:0] m0_rdata_a, m1_rdata_a;
    logic        mem_en_a, mem_we_a, stall_a;
    logic [31:0] mem_addr_a, mem_wdata_a, mem_rdata_a, stall_cnt_a;
    // instance B signals
    logic        m0_req_b, m0_we_b, m1_req_b, m1_we_b;
    logic [31:0] m0_addr_b, m0_wdata_b, m1_addr_b, m1_wdata_b;
    logic        m0_gnt_b, m0_rvalid_b, m1_gnt_b, m1_rvalid_b;
    logic [31:0] m0_rdata_b, m1_rdata_b;
    logic        mem_en_b, mem_we_b, stall_b;
    logic [31:0] mem_addr_b, mem_wdata_b, mem_rdata_b, stall_cnt_b;

    dmem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(1)) u_a (
        .clk_i(clk), .rst_i(rst_n),
        .m0_req_i(m0_req_a), .m0_we_i(m0_we_a), .m0_addr_i(m0_addr_a), .m0_wdata_i(m0_wdata_a),
        .m0_gnt_o(m0_gnt_a), .m0_rvalid_o(m0_rvalid_a), .m0_rdata_o(m0_rdata_a),
        .m1_req_i(m1_req_a), .m1_we_i(m1_we_a), .m1_addr_i(m1_addr_a), .m1_wdata_i(m1_wdata_a),
        .m1_gnt_o(m1_gnt_a), .m1_rvalid_o(m1_rvalid_a), .m1_rdata_o(m1_rdata_a),
        .mem_en_o(mem_en_a), .mem_we_o(mem_we_a), .mem_addr_o(mem_addr_a),
        .mem_wdata_o(mem_wdata_a), .mem_rdata_i(mem_rdata_a),
        .stall_o(stall_a), .stall_cnt_o(stall_cnt_a)
    );

    dmem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(3)) u_b (
        .clk_i(clk), .rst_i(rst_n),
        .m0_req_i(m0_req_b), .m0_we_i(m0_we_b), .m0_addr_i(m0_addr_b), .m0_wdata_i(m0_wdata_b),
        .m0_gnt_o(m0_gnt_b), .m0_rvalid_o(m0_rvalid_b), .m0_rdata_o(m0_rdata_b),
        .m1_req_i(m1_req_b), .m1_we_i(m1_we_b), .m1_addr_i(m1_addr_b), .m1_wdata_i(m1_wdata_b),
        .m1_gnt_o(m1_gnt_b), .m1_rvalid_o(m1_rvalid_b), .m1_rdata_o(m1_rdata_b),
        .mem_en_o(mem_en_b), .mem_we_o(mem_we_b), .mem_addr_o(mem_addr_b),
        .mem_wdata_o(mem_wdata_b), .mem_rdata_i(mem_rdata_b),
        .stall_o(stall_b), .stall_cnt_o(stall_cnt_b)
    );

    // memory A: read data appears 1 cycle after the strobe and holds
    logic [31:0] mem_a [0:15];
    always @(posedge clk) begin
        if (mem_en_a) begin
            if (mem_we_a) mem_a[mem_addr_a[5:2]] <= mem_wdata_a;
            else          mem_rdata_a <= mem_a[mem_addr_a[5:2]];
        end
    end

    // memory B: read data appears 3 cycles after the strobe and holds
    logic [31:0] mem_b [0:15];
    logic [31:0] d1_b, d2_b;
    logic        v1_b, v2_b;
    always @(posedge clk) begin
        if (mem_en_b && mem_we_b) mem_b[mem_addr_b[5:2]] <= mem_wdata_b;
        d1_b <= mem_b[mem_addr_b[5:2]];
        v1_b <= mem_en_b && !mem_we_b;
        d2_b <= d1_b;
        v2_b <= v1_b;
        if (v2_b) mem_rdata_b <= d2_b;
    end

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    logic [15:0] g0_v, g1_v, r0_v, r1_v, st_v, en_v;
    logic [31:0] rd0, rd1;

    task automatic clr();
        g0_v = '0; g1_v = '0; r0_v = '0; r1_v = '0; st_v = '0; en_v = '0;
        rd0 = 32'hDEAD_BEEF;
        rd1 = 32'hDEAD_BEEF;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Samples cycles [start, start+n) at negedge; a requester drops req after its gnt.
    task automatic run(input bit sel, input int unsigned start, input int unsigned n);
        for (int unsigned i = start; i < start + n; i++) begin
            @(negedge clk);
            g0_v[i] = sel ? m0_gnt_b    : m0_gnt_a;
            g1_v[i] = sel ? m1_gnt_b    : m1_gnt_a;
            r0_v[i] = sel ? m0_rvalid_b : m0_rvalid_a;
            r1_v[i] = sel ? m1_rvalid_b : m1_rvalid_a;
            st_v[i] = sel ? stall_b     : stall_a;
            en_v[i] = sel ? mem_en_b    : mem_en_a;
            if (r0_v[i]) rd0 = sel ? m0_rdata_b : m0_rdata_a;
            if (r1_v[i]) rd1 = sel ? m1_rdata_b : m1_rdata_a;
            tick();
            if (g0_v[i]) begin
                if (sel) m0_req_b = 1'b0; else m0_req_a = 1'b0;
            end
            if (g1_v[i]) begin
                if (sel) m1_req_b = 1'b0; else m1_req_a = 1'b0;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        mem_a[0] = 32'd5;
        rst_n = 1'b0;
        m0_req_a = 1'b1; m0_we_a = 1'b0; m0_addr_a = '0; m0_wdata_a = '0;
        m1_req_a = 1'b1; m1_we_a = 1'b0; m1_addr_a = '0; m1_wdata_a = '0;
        m0_req_b = 1'b1; m0_we_b = 1'b0; m0_addr_b = '0; m0_wdata_b = '0;
        m1_req_b = 1'b1; m1_we_b = 1'b0; m1_addr_b = '0; m1_wdata_b = '0;

        // 1. reset held 3 cycles with both requests high
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ctl_a", 32'({m0_gnt_a, m1_gnt_a, m0_rvalid_a, m1_rvalid_a, mem_en_a, mem_we_a, stall_a}), 32'd0);
        chk("rst_bus_a", mem_addr_a | mem_wdata_a | m0_rdata_a | m1_rdata_a, 32'd0);
        chk("rst_cnt_a", stall_cnt_a, 32'd0);
        chk("rst_ctl_b", 32'({m0_gnt_b, m1_gnt_b, m0_rvalid_b, m1_rvalid_b, mem_en_b, mem_we_b, stall_b}), 32'd0);
        chk("rst_cnt_b", stall_cnt_b, 32'd0);
        tick();
        rst_n = 1'b1;
        m0_req_a = 1'b0; m1_req_a = 1'b0; m0_req_b = 1'b0; m1_req_b = 1'b0;
        tick();

        // 2. m0 read of 0x0 on MEM_LAT=1
        clr();
        m0_req_a = 1'b1; m0_we_a = 1'b0; m0_addr_a = 32'h0;
        run(1'b0, 0, 5);
        chk("t2_gnt0", 32'(g0_v), 32'h0002);
        chk("t2_rv0", 32'(r0_v), 32'h0008);
        chk("t2_rdata0", rd0, 32'd5);
        chk("t2_stall", 32'(st_v), 32'h0007);
        chk("t2_en", 32'(en_v), 32'h0002);
        chk("t2_cnt", stall_cnt_a, 32'd3);

        // 3a. tie: m0 write 0x4=7, m1 read 0x4 -> m0 first, m1 reads 7
        clr();
        m0_req_a = 1'b1; m0_we_a = 1'b1; m0_addr_a = 32'h4; m0_wdata_a = 32'd7;
        m1_req_a = 1'b1; m1_we_a = 1'b0; m1_addr_a = 32'h4;
        run(1'b0, 0, 8);
        chk("t3a_gnt0", 32'(g0_v), 32'h0002);
        chk("t3a_rv0", 32'(r0_v), 32'h0008);
        chk("t3a_gnt1", 32'(g1_v), 32'h0010);
        chk("t3a_rv1", 32'(r1_v), 32'h0040);
        chk("t3a_wr_rdata0", rd0, 32'd0);
        chk("t3a_rdata1", rd1, 32'd7);
        chk("t3a_stall", 32'(st_v), 32'h0007);

        // 3b. tie again: pointer now favours m1; m1 reads 7, then m0 writes 0xA
        clr();
        m0_req_a = 1'b1; m0_we_a = 1'b1; m0_addr_a = 32'h4; m0_wdata_a = 32'hA;
        m1_req_a = 1'b1; m1_we_a = 1'b0; m1_addr_a = 32'h4;
        run(1'b0, 0, 8);
        chk("t3b_gnt1", 32'(g1_v), 32'h0002);
        chk("t3b_rv1", 32'(r1_v), 32'h0008);
        chk("t3b_gnt0", 32'(g0_v), 32'h0010);
        chk("t3b_rv0", 32'(r0_v), 32'h0040);
        chk("t3b_rdata1", rd1, 32'd7);
        chk("t3b_stall", 32'(st_v), 32'h003F);
        chk("t3b_cnt", stall_cnt_a, 32'd12);

        // 3c. m1 alone reads back the later write
        clr();
        m1_req_a = 1'b1; m1_we_a = 1'b0; m1_addr_a = 32'h4;
        run(1'b0, 0, 5);
        chk("t3c_rv1", 32'(r1_v), 32'h0008);
        chk("t3c_rdata1", rd1, 32'hA);
        chk("t3c_stall", 32'(st_v), 32'h0000);

        // 4. MEM_LAT=3: m1 write 0x8=9; m0 read 0x8 requested during WAIT
        clr();
        m1_req_b = 1'b1; m1_we_b = 1'b1; m1_addr_b = 32'h8; m1_wdata_b = 32'd9;
        run(1'b1, 0, 3);
        m0_req_b = 1'b1; m0_we_b = 1'b0; m0_addr_b = 32'h8;
        run(1'b1, 3, 9);
        chk("t4_en", 32'(en_v), 32'h0042);
        chk("t4_gnt1", 32'(g1_v), 32'h0002);
        chk("t4_rv1", 32'(r1_v), 32'h0020);
        chk("t4_gnt0", 32'(g0_v), 32'h0040);
        chk("t4_rv0", 32'(r0_v), 32'h0400);
        chk("t4_rdata0", rd0, 32'd9);
        chk("t4_stall", 32'(st_v), 32'h03F8);
        chk("t4_cnt", stall_cnt_b, 32'd7);

        // 5. reset pulse while the m0 read sits in WAIT
        clr();
        m0_req_a = 1'b1; m0_we_a = 1'b0; m0_addr_a = 32'h0;
        run(1'b0, 0, 2);
        rst_n = 1'b0;
        run(1'b0, 2, 3);
        rst_n = 1'b1;
        chk("t5_no_rv0", 32'(r0_v), 32'h0000);
        chk("t5_gnt0", 32'(g0_v), 32'h0002);
        chk("t5_state", 32'(u_a.state_q), 32'(IDLE));
        tick();
        clr();
        m0_req_a = 1'b1;
        run(1'b0, 0, 5);
        chk("t5_rv0", 32'(r0_v), 32'h0008);
        chk("t5_rdata0", rd0, 32'd5);
        chk("t5_cnt", stall_cnt_a, 32'd3);

        // 6. stall counter saturation
        force u_a.stall_cnt_q = 32'hFFFF_FFFE;
        #1;
        release u_a.stall_cnt_q;
        #1;
        chk("t6_preset", stall_cnt_a, 32'hFFFF_FFFE);
        clr();
        m0_req_a = 1'b1;
        run(1'b0, 0, 5);
        chk("t6_stall", 32'(st_v), 32'h0007);
        chk("t6_sat", stall_cnt_a, 32'hFFFF_FFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
